// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver:
// segment encoding, slot indices and the BCD converter state type.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [2:0] SLOT_ONES   = 3'd0;
    localparam logic [2:0] SLOT_TENS   = 3'd1;
    localparam logic [2:0] SLOT_HUNDS  = 3'd2;
    localparam logic [2:0] SLOT_HEX_LO = 3'd6;
    localparam logic [2:0] SLOT_HEX_HI = 3'd7;

    typedef enum logic [1:0] {
        CONV_IDLE   = 2'd0,
        CONV_SHIFT  = 2'd1,
        CONV_COMMIT = 2'd2
    } conv_state_t;

    // Active-low gfedcba pattern for one hex digit
    function automatic logic [6:0] hex_to_seg(input logic [3:0] i_val);
        logic [6:0] r_seg;
        case (i_val)
            4'h0:    r_seg = 7'b1000000;
            4'h1:    r_seg = 7'b1111001;
            4'h2:    r_seg = 7'b0100100;
            4'h3:    r_seg = 7'b0110000;
            4'h4:    r_seg = 7'b0011001;
            4'h5:    r_seg = 7'b0010010;
            4'h6:    r_seg = 7'b0000010;
            4'h7:    r_seg = 7'b1111000;
            4'h8:    r_seg = 7'b0000000;
            4'h9:    r_seg = 7'b0010000;
            4'hA:    r_seg = 7'b0001000;
            4'hB:    r_seg = 7'b0000011;
            4'hC:    r_seg = 7'b1000110;
            4'hD:    r_seg = 7'b0100001;
            4'hE:    r_seg = 7'b0000110;
            default: r_seg = 7'b0001110;
        endcase
        return r_seg;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd.sv
// Sequential shift-add-3 binary-to-BCD converter for one byte.
// Result is presented during the single COMMIT cycle (o_done high).
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_start,
    input  logic [7:0] i_bin,
    output logic       o_busy,
    output logic       o_done,
    output logic [9:0] o_bcd,
    output logic [7:0] o_bin
);

    conv_state_t r_state;
    conv_state_t w_next_state;
    logic [7:0]  r_sh;
    logic [7:0]  r_bin;
    logic [9:0]  r_acc;
    logic [3:0]  r_count;
    logic [3:0]  w_ones_adj;
    logic [3:0]  w_tens_adj;

    assign w_ones_adj = (r_acc[3:0] >= 4'd5) ? r_acc[3:0] + 4'd3 : r_acc[3:0];
    assign w_tens_adj = (r_acc[7:4] >= 4'd5) ? r_acc[7:4] + 4'd3 : r_acc[7:4];

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= CONV_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CONV_IDLE:   if (i_start) w_next_state = CONV_SHIFT;
            CONV_SHIFT:  if (r_count == 4'd1) w_next_state = CONV_COMMIT;
            CONV_COMMIT: w_next_state = CONV_IDLE;
            default:     w_next_state = CONV_IDLE;
        endcase
    end

    // Hundreds field is only 2 bits wide and can never reach 5, so it needs no adjust
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_sh    <= 8'd0;
            r_bin   <= 8'd0;
            r_acc   <= 10'd0;
            r_count <= 4'd0;
        end else begin
            case (r_state)
                CONV_IDLE: begin
                    if (i_start) begin
                        r_sh    <= i_bin;
                        r_bin   <= i_bin;
                        r_acc   <= 10'd0;
                        r_count <= 4'd8;
                    end
                end
                CONV_SHIFT: begin
                    r_acc   <= {r_acc[8], w_tens_adj, w_ones_adj, r_sh[7]};
                    r_sh    <= {r_sh[6:0], 1'b0};
                    r_count <= r_count - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != CONV_IDLE);
    assign o_done = (r_state == CONV_COMMIT);
    assign o_bcd  = r_acc;
    assign o_bin  = r_bin;

endmodule

// File: rtl/seg7_scan_driver.sv
// 8-digit multiplexed 7-segment driver: decimal on digits 2..0 (leading
// zeros blanked), hex on digits 7..6, digits 5..3 blank.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic [7:0] i_data,
    output logic [7:0] o_cathodes,
    output logic [7:0] o_anodes
);

    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

    logic [PRESC_W-1:0] r_presc;
    logic [2:0]         r_idx;
    logic [7:0]         r_last;
    logic [9:0]         r_shown_bcd;
    logic [7:0]         r_shown_hex;
    logic [7:0]         r_anodes;
    logic [7:0]         r_cathodes;

    logic               w_start;
    logic               w_busy;
    logic               w_done;
    logic [9:0]         w_bcd;
    logic [7:0]         w_bin;
    logic               w_wrap;
    logic [3:0]         w_hunds;
    logic [3:0]         w_tens;
    logic [6:0]         w_seg;

    assign w_start = !w_busy && (i_data != r_last);
    assign w_wrap  = (r_presc == PRESC_MAX);
    assign w_hunds = {2'b00, r_shown_bcd[9:8]};
    assign w_tens  = r_shown_bcd[7:4];

    bin2bcd_seq u_bin2bcd (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_start  (w_start),
        .i_bin    (i_data),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_bcd    (w_bcd),
        .o_bin    (w_bin)
    );

    // Decimal and hex are committed together so the two halves never disagree
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_last      <= 8'd0;
            r_shown_bcd <= 10'd0;
            r_shown_hex <= 8'd0;
        end else begin
            if (w_start) r_last <= i_data;
            if (w_done) begin
                r_shown_bcd <= w_bcd;
                r_shown_hex <= w_bin;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
        end else if (w_wrap) begin
            r_presc <= '0;
            r_idx   <= r_idx + 3'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_comb begin
        w_seg = SEG_BLANK;
        case (r_idx)
            SLOT_ONES:   w_seg = hex_to_seg(r_shown_bcd[3:0]);
            SLOT_TENS:   if (w_hunds != 4'd0 || w_tens != 4'd0) w_seg = hex_to_seg(w_tens);
            SLOT_HUNDS:  if (w_hunds != 4'd0) w_seg = hex_to_seg(w_hunds);
            SLOT_HEX_LO: w_seg = hex_to_seg(r_shown_hex[3:0]);
            SLOT_HEX_HI: w_seg = hex_to_seg(r_shown_hex[7:4]);
            default:     w_seg = SEG_BLANK;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_anodes   <= 8'hFF;
            r_cathodes <= 8'hFF;
        end else begin
            r_anodes   <= ~(8'b1 << r_idx);
            r_cathodes <= {1'b1, w_seg};
        end
    end

    assign o_anodes   = r_anodes;
    assign o_cathodes = r_cathodes;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with a 4-cycle digit slot.
module tb_seg7_scan_driver;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic [7:0] cathodes;
    logic [7:0] anodes;

    int testsRun;
    int testsFailed;

    seg7_scan_driver #(.REFRESH_DIV(4)) dut (
        .i_clk      (clk),
        .i_resetn   (rst_n),
        .i_data     (data),
        .o_cathodes (cathodes),
        .o_anodes   (anodes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Structural invariants watched on every cycle out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            testsRun++;
            assert (($countones(~anodes) <= 1) && (cathodes[7] === 1'b1)) else begin
                testsFailed++;
                $error("[TB] FAIL anode_onehot_dp observed anodes=%h cathodes=%h expected <=1 anode low and dp=1",
                       anodes, cathodes);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] value, input int cycles);
        data = value;
        repeat (cycles) @(negedge clk);
    endtask

    // Waits (bounded) for digit slot k, then checks its cathode pattern
    task automatic checkSlot(input string tag, input int k, input logic [7:0] expected);
        logic [7:0] expAnode;
        expAnode = ~(8'b1 << k);
        for (int i = 0; i < 40; i++) begin
            if (anodes === expAnode) break;
            @(negedge clk);
        end
        checkOutput($sformatf("%s_anode%0d", tag, k), anodes, expAnode);
        checkOutput($sformatf("%s_slot%0d", tag, k), cathodes, expected);
    endtask

    // exp packs slot patterns as {s7,s6,s5,s4,s3,s2,s1,s0}
    task automatic checkDisplay(input string tag, input logic [63:0] exp);
        for (int k = 0; k < 8; k++) checkSlot(tag, k, exp[8*k +: 8]);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        data        = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("reset_anodes", anodes, 8'hFF);
        checkOutput("reset_cathodes", cathodes, 8'hFF);

        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("scan_first_anode", anodes, 8'hFE);
        checkOutput("scan_first_cathode", cathodes, 8'hC0);
        for (int k = 1; k <= 8; k++) begin
            logic [7:0] expAnode;
            repeat (4) @(negedge clk);
            expAnode = ~(8'b1 << (k % 8));
            checkOutput($sformatf("scan_step%0d", k), anodes, expAnode);
        end

        applyStimulus(8'hFF, 12);
        checkDisplay("v255", {8'h8E, 8'h8E, 8'hFF, 8'hFF, 8'hFF, 8'hA4, 8'h92, 8'h92});

        applyStimulus(8'h07, 12);
        checkDisplay("v7", {8'hC0, 8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8});

        applyStimulus(8'd100, 12);
        checkDisplay("v100", {8'h82, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0});

        applyStimulus(8'd0, 12);
        checkDisplay("v0", {8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});

        applyStimulus(8'd12, 3);
        applyStimulus(8'd200, 25);
        checkDisplay("v200", {8'hC6, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'hA4, 8'hC0, 8'hC0});

        applyStimulus(8'hAB, 4);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_anodes", anodes, 8'hFF);
        checkOutput("midreset_cathodes", cathodes, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (11) @(negedge clk);
        checkDisplay("v171", {8'h88, 8'h83, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hF8, 8'hF9});

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
